// File: rtl/pi1_arb_pkg.sv
// rtl/pi1_arb_pkg.sv - shared PerInt op codes, arbiter state type and sizing helpers
// Purpose: common definitions imported by pi1_arb and pi1_rrpick.
// Contents: PerInt op encodings, arbiter FSM state enum, clog2 and wrap-increment helpers.
package pi1_arb_pkg;

    localparam logic [1:0] PINOOP = 2'b00;
    localparam logic [1:0] PIWROP = 2'b01;
    localparam logic [1:0] PIRDOP = 2'b10;
    localparam logic [1:0] PIRWOP = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Index increment that wraps at count-1 explicitly, so non-power-of-2
    // counts never rely on register overflow.
    function automatic int wrap_inc(input int idx, input int count);
        return (idx == count - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/pi1_rrpick.sv
// rtl/pi1_rrpick.sv - combinational round-robin requester picker
// Purpose: find the first asserted request scanning from rrptr_i upward, modulo MASTERCOUNT.
// Ports:
//   req_i    in  MASTERCOUNT  request vector
//   rrptr_i  in  IDXW         index with highest priority
//   pick_o   out IDXW         first requester at or after rrptr_i
//   anyreq_o out 1            any request asserted
module pi1_rrpick #(
    parameter int MASTERCOUNT = 2,
    parameter int IDXW        = 1
) (
    input  logic [MASTERCOUNT-1:0] req_i,
    input  logic [IDXW-1:0]        rrptr_i,
    output logic [IDXW-1:0]        pick_o,
    output logic                   anyreq_o
);

    logic found;
    int   j;

    always_comb begin
        pick_o   = '0;
        found    = 1'b0;
        j        = 0;
        anyreq_o = |req_i;
        for (int k = 0; k < MASTERCOUNT; k++) begin
            // rrptr_i is always < MASTERCOUNT, so a single subtraction wraps.
            j = int'(rrptr_i) + k;
            if (j >= MASTERCOUNT) begin
                j = j - MASTERCOUNT;
            end
            if (!found && req_i[j]) begin
                found  = 1'b1;
                pick_o = IDXW'(j);
            end
        end
    end

endmodule

// File: rtl/pi1_arb.sv
// rtl/pi1_arb.sv - single-clock round-robin PerInt arbiter with grant quantum
// Purpose: share one PerInt slave among MASTERCOUNT same-clock masters; route read data back.
// Ports:
//   clk_i, rst_i             clock, async active-high reset
//   m_*_i_flat / m_*_o_flat  per-master op/addr/data/sel in, read data and rdy out
//   s_op_o .. s_sel_o        request to slave from the granted master
//   s_data_i, s_rdy_i        slave read data and ready
module pi1_arb
    import pi1_arb_pkg::*;
#(
    parameter  int MASTERCOUNT = 2,
    parameter  int ARCHBITSZ   = 16,
    parameter  int QUANTUM     = 4,
    localparam int ADDRBITSZ   = ARCHBITSZ - clog2(ARCHBITSZ / 8),
    localparam int SELW        = ARCHBITSZ / 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [2*MASTERCOUNT-1:0]         m_op_i_flat,
    input  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_addr_i_flat,
    input  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_i_flat,
    output logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_o_flat,
    input  logic [SELW*MASTERCOUNT-1:0]      m_sel_i_flat,
    output logic [MASTERCOUNT-1:0]           m_rdy_o_flat,
    output logic [1:0]                       s_op_o,
    output logic [ADDRBITSZ-1:0]             s_addr_o,
    output logic [ARCHBITSZ-1:0]             s_data_o,
    input  logic [ARCHBITSZ-1:0]             s_data_i,
    output logic [SELW-1:0]                  s_sel_o,
    input  logic                             s_rdy_i
);

    localparam int IDXW = clog2(MASTERCOUNT);
    localparam int QW   = (QUANTUM > 1) ? clog2(QUANTUM) : 1;

    logic [1:0]           m_op   [MASTERCOUNT];
    logic [ADDRBITSZ-1:0] m_addr [MASTERCOUNT];
    logic [ARCHBITSZ-1:0] m_data [MASTERCOUNT];
    logic [SELW-1:0]      m_sel  [MASTERCOUNT];
    logic [MASTERCOUNT-1:0] req;

    arb_state_e      state_q, state_d;
    logic [IDXW-1:0] gntidx_q, gntidx_d;
    logic [IDXW-1:0] rrptr_q, rrptr_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic            rtnvld_q, rtnvld_d;
    logic [IDXW-1:0] rtnidx_q, rtnidx_d;

    logic            gntvld;
    logic [1:0]      op_g;
    logic            accept;
    logic            capture;
    logic            others;
    logic [MASTERCOUNT-1:0] req_oth;
    logic [IDXW-1:0] pick;
    logic            anyreq;
    logic [IDXW-1:0] gnt_next;

    genvar g;
    generate
        for (g = 0; g < MASTERCOUNT; g++) begin : g_master
            logic [ARCHBITSZ-1:0] rdata_q;

            assign m_op[g]   = m_op_i_flat[2*g +: 2];
            assign m_addr[g] = m_addr_i_flat[ADDRBITSZ*g +: ADDRBITSZ];
            assign m_data[g] = m_data_i_flat[ARCHBITSZ*g +: ARCHBITSZ];
            assign m_sel[g]  = m_sel_i_flat[SELW*g +: SELW];
            assign req[g]    = (m_op[g] != PINOOP);

            assign m_rdy_o_flat[g] = gntvld && (gntidx_q == IDXW'(g)) && s_rdy_i;

            // Each master's read data register only loads when a return
            // addressed to it is captured.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    rdata_q <= '0;
                end else if (capture && (rtnidx_q == IDXW'(g))) begin
                    rdata_q <= s_data_i;
                end
            end

            assign m_data_o_flat[ARCHBITSZ*g +: ARCHBITSZ] = rdata_q;
        end
    endgenerate

    pi1_rrpick #(
        .MASTERCOUNT (MASTERCOUNT),
        .IDXW        (IDXW)
    ) u_rrpick (
        .req_i    (req),
        .rrptr_i  (rrptr_q),
        .pick_o   (pick),
        .anyreq_o (anyreq)
    );

    assign gntvld   = (state_q == ST_GRANT);
    assign op_g     = m_op[gntidx_q];
    assign s_op_o   = gntvld ? op_g : PINOOP;
    assign s_addr_o = m_addr[gntidx_q];
    assign s_data_o = m_data[gntidx_q];
    assign s_sel_o  = m_sel[gntidx_q];

    assign accept   = gntvld && s_rdy_i && (op_g != PINOOP);
    assign capture  = s_rdy_i && rtnvld_q;
    assign gnt_next = IDXW'(wrap_inc(int'(gntidx_q), MASTERCOUNT));

    always_comb begin
        req_oth           = req;
        req_oth[gntidx_q] = 1'b0;
        others            = |req_oth;
    end

    always_comb begin
        state_d  = state_q;
        gntidx_d = gntidx_q;
        rrptr_d  = rrptr_q;
        qcnt_d   = qcnt_q;
        rtnvld_d = rtnvld_q;
        rtnidx_d = rtnidx_q;

        case (state_q)
            ST_IDLE: begin
                if (anyreq) begin
                    state_d  = ST_GRANT;
                    gntidx_d = pick;
                    qcnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (s_rdy_i && (op_g == PINOOP)) begin
                    state_d = ST_IDLE;
                    rrptr_d = gnt_next;
                end else if (accept && (qcnt_q == QW'(QUANTUM - 1)) && others) begin
                    state_d = ST_IDLE;
                    rrptr_d = gnt_next;
                end else if (accept && (qcnt_q != QW'(QUANTUM - 1))) begin
                    qcnt_d = qcnt_q + QW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The capture above uses rtnidx_q; a read accepted on the same edge
        // replaces it for the following return.
        if (accept) begin
            rtnvld_d = op_g[1];
            if (op_g[1]) begin
                rtnidx_d = gntidx_q;
            end
        end else if (capture) begin
            rtnvld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            gntidx_q <= '0;
            rrptr_q  <= '0;
            qcnt_q   <= '0;
            rtnvld_q <= 1'b0;
            rtnidx_q <= '0;
        end else begin
            state_q  <= state_d;
            gntidx_q <= gntidx_d;
            rrptr_q  <= rrptr_d;
            qcnt_q   <= qcnt_d;
            rtnvld_q <= rtnvld_d;
            rtnidx_q <= rtnidx_d;
        end
    end

endmodule

// File: tb/tb_pi1_arb.sv
// tb/tb_pi1_arb.sv - directed self-checking bench for pi1_arb (2 and 3 masters)
module tb_pi1_arb;

    logic        clk;
    logic        rst;

    logic [3:0]  m_op;
    logic [29:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic [3:0]  m_sel;
    logic [1:0]  m_rdy;
    logic [1:0]  s_op;
    logic [14:0] s_addr;
    logic [15:0] s_wdata;
    logic [15:0] s_rdata;
    logic [1:0]  s_sel;
    logic        s_rdy;

    logic [5:0]  m3_op;
    logic [44:0] m3_addr;
    logic [47:0] m3_wdata;
    logic [47:0] m3_rdata;
    logic [5:0]  m3_sel;
    logic [2:0]  m3_rdy;
    logic [1:0]  s3_op;
    logic [14:0] s3_addr;
    logic [15:0] s3_wdata;
    logic [15:0] s3_rdata;
    logic [1:0]  s3_sel;
    logic        s3_rdy;

    int checks;
    int errors;

    pi1_arb #(.MASTERCOUNT(2), .ARCHBITSZ(16), .QUANTUM(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .m_op_i_flat   (m_op),
        .m_addr_i_flat (m_addr),
        .m_data_i_flat (m_wdata),
        .m_data_o_flat (m_rdata),
        .m_sel_i_flat  (m_sel),
        .m_rdy_o_flat  (m_rdy),
        .s_op_o        (s_op),
        .s_addr_o      (s_addr),
        .s_data_o      (s_wdata),
        .s_data_i      (s_rdata),
        .s_sel_o       (s_sel),
        .s_rdy_i       (s_rdy)
    );

    pi1_arb #(.MASTERCOUNT(3), .ARCHBITSZ(16), .QUANTUM(4)) dut3 (
        .clk_i         (clk),
        .rst_i         (rst),
        .m_op_i_flat   (m3_op),
        .m_addr_i_flat (m3_addr),
        .m_data_i_flat (m3_wdata),
        .m_data_o_flat (m3_rdata),
        .m_sel_i_flat  (m3_sel),
        .m_rdy_o_flat  (m3_rdy),
        .s_op_o        (s3_op),
        .s_addr_o      (s3_addr),
        .s_data_o      (s3_wdata),
        .s_data_i      (s3_rdata),
        .s_sel_o       (s3_sel),
        .s_rdy_i       (s3_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_op     = '0;
        m_addr   = '0;
        m_wdata  = '0;
        m_sel    = '0;
        s_rdata  = '0;
        s_rdy    = 1'b0;
        m3_op    = '0;
        m3_addr  = '0;
        m3_wdata = '0;
        m3_sel   = '0;
        s3_rdata = '0;
        s3_rdy   = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        m_op = 4'b0101;
        s_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (s_op !== 2'b00) begin
            errors++;
            $display("FAIL reset_s_op: got %b expected 00", s_op);
        end
        checks++;
        if (m_rdy !== 2'b00) begin
            errors++;
            $display("FAIL reset_m_rdy: got %b expected 00", m_rdy);
        end
        checks++;
        if (m_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_m_data: got %h expected 00000000", m_rdata);
        end
        checks++;
        if (m3_rdy !== 3'b000 || s3_op !== 2'b00) begin
            errors++;
            $display("FAIL reset_dut3: got rdy %b op %b expected 000 00", m3_rdy, s3_op);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        m_op    = 4'b0010;
        s_rdy   = 1'b1;
        s_rdata = 16'hAAAA;
        step();
        #1;
        checks++;
        if (m_rdy !== 2'b01) begin
            errors++;
            $display("FAIL midrst_grant0: got %b expected 01", m_rdy);
        end
        step();
        step();
        #1;
        checks++;
        if (m_rdata[15:0] !== 16'hAAAA) begin
            errors++;
            $display("FAIL midrst_capture: got %h expected aaaa", m_rdata[15:0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (s_op !== 2'b00 || m_rdy !== 2'b00 || m_rdata !== 32'h0) begin
            errors++;
            $display("FAIL midrst_async: got op %b rdy %b data %h expected 00 00 00000000",
                     s_op, m_rdy, m_rdata);
        end
        #1;
        rst  = 1'b0;
        m_op = 4'b1010;
        step();
        #1;
        checks++;
        if (m_rdy !== 2'b01) begin
            errors++;
            $display("FAIL midrst_first_grant: got %b expected 01", m_rdy);
        end
    endtask

    task automatic test_basic_read();
        do_reset();
        m_op    = 4'b1000;
        m_addr  = {15'h0012, 15'h0000};
        m_wdata = {16'h5A5A, 16'h0000};
        m_sel   = 4'b1000;
        s_rdy   = 1'b1;
        #1;
        checks++;
        if (m_rdy !== 2'b00) begin
            errors++;
            $display("FAIL read_no_rdy_same_cycle: got %b expected 00", m_rdy);
        end
        step();
        #1;
        checks++;
        if (m_rdy !== 2'b10 || s_op !== 2'b10 || s_addr !== 15'h0012) begin
            errors++;
            $display("FAIL read_grant1: got rdy %b op %b addr %h expected 10 10 0012",
                     m_rdy, s_op, s_addr);
        end
        checks++;
        if (s_sel !== 2'b10 || s_wdata !== 16'h5A5A) begin
            errors++;
            $display("FAIL read_mux_fields: got sel %b data %h expected 10 5a5a", s_sel, s_wdata);
        end
        step();
        m_op    = 4'b0000;
        s_rdata = 16'hBEEF;
        step();
        s_rdata = 16'h0000;
        #1;
        checks++;
        if (m_rdata[31:16] !== 16'hBEEF) begin
            errors++;
            $display("FAIL read_data1: got %h expected beef", m_rdata[31:16]);
        end
        checks++;
        if (m_rdata[15:0] !== 16'h0000) begin
            errors++;
            $display("FAIL read_data0_untouched: got %h expected 0000", m_rdata[15:0]);
        end
        checks++;
        if (m_rdy !== 2'b00) begin
            errors++;
            $display("FAIL read_release: got %b expected 00", m_rdy);
        end
    endtask

    task automatic test_quantum();
        logic [1:0] exp_rdy [11];
        logic [1:0] exp_op;
        exp_rdy = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                    2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
        do_reset();
        m_op  = 4'b0101;
        s_rdy = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            #1;
            exp_op = (exp_rdy[i] != 2'b00) ? 2'b01 : 2'b00;
            checks++;
            if (m_rdy !== exp_rdy[i] || s_op !== exp_op) begin
                errors++;
                $display("FAIL quantum_cycle%0d: got rdy %b op %b expected %b %b",
                         i, m_rdy, s_op, exp_rdy[i], exp_op);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        m_op   = 4'b0001;
        m_addr = {15'h0007, 15'h0005};
        s_rdy  = 1'b0;
        step();
        m_op = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (s_op !== 2'b01 || s_addr !== 15'h0005 || m_rdy !== 2'b00) begin
                errors++;
                $display("FAIL stall_cycle%0d: got op %b addr %h rdy %b expected 01 0005 00",
                         i, s_op, s_addr, m_rdy);
            end
            step();
        end
        s_rdy = 1'b1;
        #1;
        checks++;
        if (m_rdy !== 2'b01 || s_addr !== 15'h0005) begin
            errors++;
            $display("FAIL stall_resume: got rdy %b addr %h expected 01 0005", m_rdy, s_addr);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        m_op    = 4'b0010;
        s_rdy   = 1'b1;
        s_rdata = 16'hDEAD;
        step();
        #1;
        checks++;
        if (m_rdy !== 2'b01) begin
            errors++;
            $display("FAIL b2b_grant0: got %b expected 01", m_rdy);
        end
        step();
        m_op    = 4'b1000;
        s_rdata = 16'h1111;
        step();
        s_rdata = 16'hDEAD;
        #1;
        checks++;
        if (m_rdata[15:0] !== 16'h1111 || m_rdy !== 2'b00 || s_op !== 2'b00) begin
            errors++;
            $display("FAIL b2b_first_return: got data0 %h rdy %b op %b expected 1111 00 00",
                     m_rdata[15:0], m_rdy, s_op);
        end
        step();
        #1;
        checks++;
        if (m_rdy !== 2'b10 || m_rdata[15:0] !== 16'h1111) begin
            errors++;
            $display("FAIL b2b_grant1: got rdy %b data0 %h expected 10 1111", m_rdy, m_rdata[15:0]);
        end
        step();
        m_op    = 4'b0000;
        s_rdata = 16'h2222;
        step();
        s_rdata = 16'hDEAD;
        #1;
        checks++;
        if (m_rdata !== 32'h2222_1111) begin
            errors++;
            $display("FAIL b2b_routing: got %h expected 22221111", m_rdata);
        end
    endtask

    task automatic test_fairness();
        int         order [4];
        int         idx;
        logic [2:0] exp_rdy;
        order = '{0, 1, 2, 0};
        do_reset();
        m3_op  = 6'b010101;
        s3_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idx     = order[k];
            exp_rdy = 3'b001 << idx;
            step();
            #1;
            checks++;
            if (m3_rdy !== exp_rdy) begin
                errors++;
                $display("FAIL fair_grant%0d: got %b expected %b", k, m3_rdy, exp_rdy);
            end
            step();
            m3_op[2*idx +: 2] = 2'b00;
            #1;
            checks++;
            if (m3_rdy !== exp_rdy || s3_op !== 2'b00) begin
                errors++;
                $display("FAIL fair_drop_cycle%0d: got rdy %b op %b expected %b 00",
                         k, m3_rdy, s3_op, exp_rdy);
            end
            step();
            m3_op[2*idx +: 2] = 2'b01;
            #1;
            checks++;
            if (m3_rdy !== 3'b000 || s3_op !== 2'b00) begin
                errors++;
                $display("FAIL fair_release%0d: got rdy %b op %b expected 000 00", k, m3_rdy, s3_op);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_reset_mid_grant();
        test_basic_read();
        test_quantum();
        test_stall();
        test_back_to_back();
        test_fairness();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
